// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and defaults for the SPI register-bank controller.
//   state_e    - controller FSM states
//   addr_valid - 1 when an address falls inside the implemented bank
package spi_reg_pkg;

   localparam int          DEF_ADDR_WIDTH = 7;
   localparam int          DEF_DATA_WIDTH = 24;
   localparam int          DEF_NUM_REGS   = 16;
   localparam logic [15:0] DEF_RO_MASK    = 16'hF000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      WAIT   = 3'd2,
      COMMIT = 3'd3,
      DONE   = 3'd4
   } state_e;

   function automatic logic addr_valid(input logic [31:0] addr, input int unsigned num_regs);
      return (addr < num_regs);
   endfunction

endpackage

// File: rtl/spi_reg_file.sv
// spi_reg_file: NUM_REGS x DATA_WIDTH storage with one write port and a flat read bus.
//   clk_i, rst_ni  clock, async active-low reset (clears the bank)
//   we_i           write enable
//   waddr_i        write index (caller guarantees it is < NUM_REGS)
//   wdata_i        write data
//   rdata_o        reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module spi_reg_file
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           we_i,
   input  logic [IDX_W-1:0]               waddr_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (we_i && (waddr_i == IDX_W'(i))) mem_q[i] <= wdata_i;
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < NUM_REGS; i++) rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
   end

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes soft SPI slave transactions into register-bank reads/writes,
// arbitrates the bank write port between SPI commits and a core status requester.
//   clk_i, rst_ni        clock, async active-low reset
//   spi_addr_i/_ready_i  address and its level strobe from the slave
//   spi_rw_i             1 = read, 0 = write
//   spi_wdata_i/spi_data_ready_i  write data and its level strobe
//   spi_rdata_o          read data to the slave, valid 2 clk after addr_ready
//   core_req_i/_addr_i/_data_i, core_ack_o  core write port (ack = write this cycle)
//   cfg_regs_o           flattened bank
//   wr_strobe_o/rd_strobe_o  one-hot 1-cycle pulses per SPI write commit / read snapshot
//   err_cnt_o            saturating invalid/RO-violation counter
//   busy_o               FSM not IDLE
//
// state  | meaning
// IDLE   | waiting for addr_ready rising edge
// LOAD   | addr latched; snapshot read data
// WAIT   | waiting for data_ready rise, or abort on addr_ready low
// COMMIT | SPI owns the write port this cycle
// DONE   | waiting for slave to clear both strobes
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                  NUM_REGS   = DEF_NUM_REGS,
   parameter logic [NUM_REGS-1:0] RO_MASK    = DEF_RO_MASK
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [ADDR_WIDTH-1:0]          spi_addr_i,
   input  logic                           spi_addr_ready_i,
   input  logic                           spi_rw_i,
   input  logic [DATA_WIDTH-1:0]          spi_wdata_i,
   input  logic                           spi_data_ready_i,
   output logic [DATA_WIDTH-1:0]          spi_rdata_o,
   input  logic                           core_req_i,
   input  logic [ADDR_WIDTH-1:0]          core_addr_i,
   input  logic [DATA_WIDTH-1:0]          core_data_i,
   output logic                           core_ack_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs_o,
   output logic [NUM_REGS-1:0]            wr_strobe_o,
   output logic [NUM_REGS-1:0]            rd_strobe_o,
   output logic [7:0]                     err_cnt_o,
   output logic                           busy_o
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    rw_q;
   logic                    addr_rdy_q, data_rdy_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [NUM_REGS-1:0]     wr_strobe_q, rd_strobe_q;
   logic [7:0]              err_q;

   logic                    addr_rise, data_rise;
   logic                    spi_valid, spi_ro, core_valid;
   logic [IDX_W-1:0]        spi_idx, core_idx;
   logic                    spi_we, rd_hit, err_inc;
   logic                    we;
   logic [IDX_W-1:0]        waddr;
   logic [DATA_WIDTH-1:0]   wdata;

   assign addr_rise  = spi_addr_ready_i & ~addr_rdy_q;
   assign data_rise  = spi_data_ready_i & ~data_rdy_q;

   assign spi_valid  = addr_valid(32'(addr_q), NUM_REGS);
   assign spi_idx    = addr_q[IDX_W-1:0];
   assign spi_ro     = RO_MASK[spi_idx];
   assign core_valid = addr_valid(32'(core_addr_i), NUM_REGS);
   assign core_idx   = core_addr_i[IDX_W-1:0];

   // SPI commit owns the write port; the core is granted on every other cycle.
   assign spi_we     = (state_q == COMMIT) && spi_valid && !spi_ro;
   assign core_ack_o = core_req_i && (state_q != COMMIT);
   assign we         = spi_we || (core_ack_o && core_valid);
   assign waddr      = spi_we ? spi_idx : core_idx;
   assign wdata      = spi_we ? spi_wdata_i : core_data_i;

   assign rd_hit     = (state_q == LOAD) && rw_q && spi_valid;
   assign err_inc    = ((state_q == LOAD) && rw_q && !spi_valid) ||
                       ((state_q == COMMIT) && (!spi_valid || spi_ro));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (addr_rise) state_d = LOAD;
         LOAD:    state_d = WAIT;
         WAIT: begin
            if (!spi_addr_ready_i) state_d = IDLE;
            else if (data_rise)    state_d = rw_q ? DONE : COMMIT;
         end
         COMMIT:  state_d = DONE;
         DONE:    if (!spi_addr_ready_i && !spi_data_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         addr_rdy_q  <= 1'b0;
         data_rdy_q  <= 1'b0;
         rdata_q     <= '0;
         wr_strobe_q <= '0;
         rd_strobe_q <= '0;
         err_q       <= '0;
      end else begin
         state_q    <= state_d;
         addr_rdy_q <= spi_addr_ready_i;
         data_rdy_q <= spi_data_ready_i;
         if ((state_q == IDLE) && addr_rise) begin
            addr_q <= spi_addr_i;
            rw_q   <= spi_rw_i;
         end
         // Snapshot comes from the bank before this edge, so a same-cycle core write is not seen.
         if (state_q == LOAD) rdata_q <= rd_hit ? cfg_regs_o[spi_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
         rd_strobe_q <= rd_hit ? (ONE << spi_idx) : '0;
         wr_strobe_q <= spi_we ? (ONE << spi_idx) : '0;
         if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      end
   end

   spi_reg_file #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_reg_file (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .rdata_o (cfg_regs_o)
   );

   assign spi_rdata_o = rdata_q;
   assign wr_strobe_o = wr_strobe_q;
   assign rd_strobe_o = rd_strobe_q;
   assign err_cnt_o   = err_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

   logic          clk, rst_n;
   logic [6:0]    spi_addr;
   logic          spi_addr_ready, spi_rw, spi_data_ready;
   logic [23:0]   spi_wdata, spi_rdata;
   logic          core_req, core_ack;
   logic [6:0]    core_addr;
   logic [23:0]   core_data;
   logic [383:0]  cfg_regs;
   logic [15:0]   wr_strobe, rd_strobe;
   logic [7:0]    err_cnt;
   logic          busy;

   int            n_vec = 0;
   int            n_err = 0;
   logic [23:0]   exp_reg [16];

   logic [23:0]   cap_rdata;
   logic [15:0]   cap_rds, cap_wrs, cap_wrs2;
   logic          cap_busy, cap_busy_end;

   spi_reg_ctrl dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .spi_addr_i       (spi_addr),
      .spi_addr_ready_i (spi_addr_ready),
      .spi_rw_i         (spi_rw),
      .spi_wdata_i      (spi_wdata),
      .spi_data_ready_i (spi_data_ready),
      .spi_rdata_o      (spi_rdata),
      .core_req_i       (core_req),
      .core_addr_i      (core_addr),
      .core_data_i      (core_data),
      .core_ack_o       (core_ack),
      .cfg_regs_o       (cfg_regs),
      .wr_strobe_o      (wr_strobe),
      .rd_strobe_o      (rd_strobe),
      .err_cnt_o        (err_cnt),
      .busy_o           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] get_reg(input int i);
      return cfg_regs[i*24 +: 24];
   endfunction

   task automatic check_bank(input string tag);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s_reg%0d", tag, i), 32'(get_reg(i)), 32'(exp_reg[i]));
   endtask

   // Full frame: addr_ready rise, data_ready rise, then both dropped.
   task automatic spi_xfer(input logic [6:0] a, input logic rw, input logic [23:0] wd);
      spi_addr = a; spi_rw = rw; spi_addr_ready = 1'b1;
      tick();                              // -> LOAD
      tick();                              // -> WAIT, rdata/rd_strobe valid
      cap_rdata = spi_rdata; cap_rds = rd_strobe; cap_busy = busy;
      spi_wdata = wd; spi_data_ready = 1'b1;
      tick();                              // -> COMMIT or DONE
      tick();                              // write lands, wr_strobe valid
      cap_wrs = wr_strobe;
      spi_addr_ready = 1'b0; spi_data_ready = 1'b0;
      tick();                              // -> IDLE
      cap_wrs2 = wr_strobe; cap_busy_end = busy;
   endtask

   initial begin
      rst_n = 1'b0;
      spi_addr = '0; spi_addr_ready = 1'b0; spi_rw = 1'b0;
      spi_wdata = '0; spi_data_ready = 1'b0;
      core_req = 1'b0; core_addr = '0; core_data = '0;
      for (int i = 0; i < 16; i++) exp_reg[i] = '0;
      #23;
      check("rst_rdata", 32'(spi_rdata), 0);
      check("rst_err", 32'(err_cnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_strobes", {wr_strobe, rd_strobe}, 0);
      check("rst_ack", 32'(core_ack), 0);
      check_bank("rst");
      @(negedge clk); rst_n = 1'b1;
      tick();

      // 1: SPI write reg3
      spi_xfer(7'd3, 1'b0, 24'hABCDEF);
      exp_reg[3] = 24'hABCDEF;
      check("t1_busy_mid", 32'(cap_busy), 1);
      check("t1_wr_strobe", 32'(cap_wrs), 32'h0008);
      check("t1_wr_strobe_end", 32'(cap_wrs2), 0);
      check("t1_busy_end", 32'(cap_busy_end), 0);
      check("t1_err", 32'(err_cnt), 0);
      check_bank("t1");

      // 2: core write reg12 (RO from SPI), invalid core addr, then SPI read reg12
      core_req = 1'b1; core_addr = 7'd12; core_data = 24'h000123;
      #1 check("t2_ack", 32'(core_ack), 1);
      tick();
      core_addr = 7'd20; core_data = 24'h999999;
      #1 check("t2_ack_invalid", 32'(core_ack), 1);
      tick();
      core_req = 1'b0;
      exp_reg[12] = 24'h000123;
      check_bank("t2_core");
      spi_xfer(7'd12, 1'b1, 24'h0);
      check("t2_rdata", 32'(cap_rdata), 32'h000123);
      check("t2_rd_strobe", 32'(cap_rds), 32'h1000);
      check("t2_no_wr_strobe", 32'(cap_wrs), 0);
      check("t2_err", 32'(err_cnt), 0);

      // 3: RO write, invalid write, invalid read
      spi_xfer(7'd13, 1'b0, 24'h131313);
      check("t3_ro_wr_strobe", 32'(cap_wrs), 0);
      check("t3_err1", 32'(err_cnt), 1);
      spi_xfer(7'd40, 1'b0, 24'h404040);
      check("t3_err2", 32'(err_cnt), 2);
      check_bank("t3_wr");
      spi_xfer(7'd40, 1'b1, 24'h0);
      check("t3_rdata_invalid", 32'(cap_rdata), 0);
      check("t3_rd_strobe_invalid", 32'(cap_rds), 0);
      check("t3_err3", 32'(err_cnt), 3);

      // 4: core request arriving on the COMMIT cycle is held off one cycle
      spi_addr = 7'd5; spi_rw = 1'b0; spi_addr_ready = 1'b1;
      tick(); tick();
      spi_wdata = 24'h555555; spi_data_ready = 1'b1;
      tick();                              // now COMMIT
      core_req = 1'b1; core_addr = 7'd7; core_data = 24'h000777;
      #1 check("t4_ack_commit", 32'(core_ack), 0);
      tick();                              // SPI write lands, now DONE
      check("t4_ack_next", 32'(core_ack), 1);
      check("t4_wr_strobe", 32'(wr_strobe), 32'h0020);
      tick();                              // core write lands
      core_req = 1'b0;
      #1 check("t4_ack_drop", 32'(core_ack), 0);
      spi_addr_ready = 1'b0; spi_data_ready = 1'b0;
      tick();
      exp_reg[5] = 24'h555555; exp_reg[7] = 24'h000777;
      check_bank("t4");

      // 5: ncs abort during WAIT
      spi_addr = 7'd6; spi_rw = 1'b0; spi_addr_ready = 1'b1;
      tick(); tick();                      // WAIT
      spi_addr_ready = 1'b0;
      tick();
      check("t5_busy", 32'(busy), 0);
      check("t5_wr_strobe", 32'(wr_strobe), 0);
      tick();
      check("t5_wr_strobe2", 32'(wr_strobe), 0);
      check_bank("t5");

      // Same-cycle core write of the reg being snapshotted: snapshot is pre-write
      spi_addr = 7'd12; spi_rw = 1'b1; spi_addr_ready = 1'b1;
      tick();                              // LOAD
      core_req = 1'b1; core_addr = 7'd12; core_data = 24'h000456;
      tick();
      core_req = 1'b0;
      check("snap_rdata", 32'(spi_rdata), 32'h000123);
      exp_reg[12] = 24'h000456;
      check("snap_reg12", 32'(get_reg(12)), 32'(exp_reg[12]));
      spi_data_ready = 1'b1;
      tick(); tick();
      check("snap_rdata_hold", 32'(spi_rdata), 32'h000123);
      spi_addr_ready = 1'b0; spi_data_ready = 1'b0;
      tick();

      // 6: async reset mid-WAIT
      spi_addr = 7'd8; spi_rw = 1'b0; spi_addr_ready = 1'b1;
      tick(); tick();                      // WAIT
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) exp_reg[i] = '0;
      check("t6_busy", 32'(busy), 0);
      check("t6_err", 32'(err_cnt), 0);
      check("t6_rdata", 32'(spi_rdata), 0);
      check("t6_strobes", {wr_strobe, rd_strobe}, 0);
      check_bank("t6_rst");
      spi_addr_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      spi_xfer(7'd8, 1'b0, 24'h888888);
      exp_reg[8] = 24'h888888;
      check("t6_wr_strobe", 32'(cap_wrs), 32'h0100);
      check_bank("t6_frame");
      spi_xfer(7'd8, 1'b1, 24'h0);
      check("t6_rdata_back", 32'(cap_rdata), 32'h888888);
      check("t6_rd_strobe", 32'(cap_rds), 32'h0100);

      // Boundaries: last valid reg (RO), first invalid, then saturation
      spi_xfer(7'd15, 1'b0, 24'h151515);
      check("bnd_ro15_err", 32'(err_cnt), 1);
      spi_xfer(7'd16, 1'b0, 24'h161616);
      check("bnd_inv16_err", 32'(err_cnt), 2);
      check_bank("bnd");
      for (int k = 0; k < 254; k++) spi_xfer(7'd127, 1'b1, 24'h0);
      check("sat_err_255", 32'(err_cnt), 255);
      spi_xfer(7'd127, 1'b1, 24'h0);
      check("sat_err_hold", 32'(err_cnt), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
